mm_read_bench: RTL and testbench

MM_READ_BENCH -- requirements
Module: mm_read_bench

---
 rtl/mm_read_bench.sv | 181 ++++++++++++++++++
 tb/tb_mm_read_bench.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_read_bench.sv
// Multi-channel AXI read bandwidth generator: each channel issues bursts over a
// programmable range and counts commands, beats, cycles and an XOR data checksum.
module mm_read_bench #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 512,
    parameter int CNT_W   = 32,
    parameter int MAX_OUT = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_CH-1:0]              ch_en,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]  base_addr,
    input  logic [NUM_CH-1:0][CNT_W-1:0]   total_beats,
    input  logic [7:0]                     burst_len,
    output logic [NUM_CH-1:0]              m_arvalid,
    input  logic [NUM_CH-1:0]              m_arready,
    output logic [NUM_CH-1:0][ADDR_W-1:0]  m_araddr,
    output logic [NUM_CH-1:0][7:0]         m_arlen,
    input  logic [NUM_CH-1:0]              m_rvalid,
    output logic [NUM_CH-1:0]              m_rready,
    input  logic [NUM_CH-1:0]              m_rlast,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  m_rdata,
    output logic [NUM_CH-1:0]              busy,
    output logic [NUM_CH-1:0]              done,
    output logic [NUM_CH-1:0][CNT_W-1:0]   cmd_cnt,
    output logic [NUM_CH-1:0][CNT_W-1:0]   beat_cnt,
    output logic [NUM_CH-1:0][CNT_W-1:0]   cyc_cnt,
    output logic [NUM_CH-1:0][31:0]        csum
);

    localparam int OUT_W   = $clog2(MAX_OUT + 1);
    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int LANES   = DATA_W / 32;
    localparam logic [OUT_W-1:0] MAX_OUT_V = OUT_W'(MAX_OUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    logic start_q;
    logic launch;

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b0;
        end else begin
            start_q <= start;
        end
    end

    assign launch = start & ~start_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t             state_reg, state_next;
            logic [ADDR_W-1:0]  addr_reg, addr_next;
            logic [CNT_W-1:0]   rem_reg, rem_next;
            logic [CNT_W-1:0]   tot_reg, tot_next;
            logic [7:0]         blen_reg, blen_next;
            logic [OUT_W-1:0]   outst_reg, outst_next;
            logic [CNT_W-1:0]   cmd_reg, cmd_next;
            logic [CNT_W-1:0]   beat_reg, beat_next;
            logic [CNT_W-1:0]   cyc_reg, cyc_next;
            logic [31:0]        csum_reg, csum_next;
            logic [31:0]        lane_x;
            logic [CNT_W-1:0]   rem_m1;
            logic [7:0]         arlen_c;
            logic               arvalid_c, active, ar_hs, r_hs, last_hs;

            always_comb begin
                lane_x = 32'd0;
                for (int l = 0; l < LANES; l++) begin
                    lane_x = lane_x ^ m_rdata[gi][l*32 +: 32];
                end
            end

            // burst_len is latched at launch so arlen cannot move under a stalled AR
            assign rem_m1    = rem_reg - CNT_W'(1);
            assign arlen_c   = (rem_m1 < CNT_W'(blen_reg)) ? rem_m1[7:0] : blen_reg;
            assign active    = (state_reg == S_ISSUE) || (state_reg == S_DRAIN);
            assign arvalid_c = (state_reg == S_ISSUE) && (rem_reg != '0) && (outst_reg < MAX_OUT_V);
            assign ar_hs     = arvalid_c & m_arready[gi];
            assign r_hs      = active & m_rvalid[gi];
            assign last_hs   = r_hs & m_rlast[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= S_IDLE;
                    addr_reg  <= '0;
                    rem_reg   <= '0;
                    tot_reg   <= '0;
                    blen_reg  <= '0;
                    outst_reg <= '0;
                    cmd_reg   <= '0;
                    beat_reg  <= '0;
                    cyc_reg   <= '0;
                    csum_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    addr_reg  <= addr_next;
                    rem_reg   <= rem_next;
                    tot_reg   <= tot_next;
                    blen_reg  <= blen_next;
                    outst_reg <= outst_next;
                    cmd_reg   <= cmd_next;
                    beat_reg  <= beat_next;
                    cyc_reg   <= cyc_next;
                    csum_reg  <= csum_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                addr_next  = addr_reg;
                rem_next   = rem_reg;
                tot_next   = tot_reg;
                blen_next  = blen_reg;
                outst_next = outst_reg;
                cmd_next   = cmd_reg;
                beat_next  = beat_reg;
                cyc_next   = cyc_reg;
                csum_next  = csum_reg;
                case (state_reg)
                    S_IDLE, S_DONE: begin
                        if (launch && ch_en[gi]) begin
                            addr_next  = base_addr[gi];
                            rem_next   = total_beats[gi];
                            tot_next   = total_beats[gi];
                            blen_next  = burst_len;
                            outst_next = '0;
                            cmd_next   = '0;
                            beat_next  = '0;
                            cyc_next   = '0;
                            csum_next  = '0;
                            state_next = (total_beats[gi] == '0) ? S_DONE : S_ISSUE;
                        end
                    end
                    S_ISSUE, S_DRAIN: begin
                        cyc_next = cyc_reg + CNT_W'(1);
                        if (ar_hs) begin
                            addr_next = addr_reg + ((ADDR_W'(arlen_c) + ADDR_W'(1)) << BYTE_SH);
                            rem_next  = rem_reg - (CNT_W'(arlen_c) + CNT_W'(1));
                            cmd_next  = cmd_reg + CNT_W'(1);
                        end
                        if (r_hs) begin
                            beat_next = beat_reg + CNT_W'(1);
                            csum_next = csum_reg ^ lane_x;
                        end
                        if (ar_hs && !last_hs) begin
                            outst_next = outst_reg + OUT_W'(1);
                        end else if (!ar_hs && last_hs) begin
                            outst_next = outst_reg - OUT_W'(1);
                        end
                        // completion is judged on next-state values so cyc_cnt stops at the last beat
                        if (state_reg == S_ISSUE) begin
                            if (ar_hs && rem_next == '0) begin
                                state_next = S_DRAIN;
                            end
                        end else if (outst_next == '0 && beat_next == tot_reg) begin
                            state_next = S_DONE;
                        end
                    end
                    default: state_next = S_IDLE;
                endcase
            end

            assign m_arvalid[gi] = arvalid_c;
            assign m_araddr[gi]  = addr_reg;
            assign m_arlen[gi]   = (state_reg == S_ISSUE) ? arlen_c : 8'd0;
            assign m_rready[gi]  = active;
            assign busy[gi]      = active;
            assign done[gi]      = (state_reg == S_DONE);
            assign cmd_cnt[gi]   = cmd_reg;
            assign beat_cnt[gi]  = beat_reg;
            assign cyc_cnt[gi]   = cyc_reg;
            assign csum[gi]      = csum_reg;
        end
    endgenerate

endmodule

// File: tb/tb_mm_read_bench.sv
// Bench for mm_read_bench: AXI read slave model, AR scoreboard, vector table
// for completed runs and directed sequences for stalls, re-launch and reset.
module tb_mm_read_bench;

    localparam int NUM_CH  = 2;
    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 512;
    localparam int CNT_W   = 32;
    localparam int MAX_OUT = 2;
    localparam int LANES   = DATA_W / 32;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           start;
    logic [NUM_CH-1:0]              ch_en;
    logic [NUM_CH-1:0][ADDR_W-1:0]  base_addr;
    logic [NUM_CH-1:0][CNT_W-1:0]   total_beats;
    logic [7:0]                     burst_len;
    logic [NUM_CH-1:0]              m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [NUM_CH-1:0][ADDR_W-1:0]  m_araddr;
    logic [NUM_CH-1:0][7:0]         m_arlen;
    logic [NUM_CH-1:0][DATA_W-1:0]  m_rdata;
    logic [NUM_CH-1:0]              busy, done;
    logic [NUM_CH-1:0][CNT_W-1:0]   cmd_cnt, beat_cnt, cyc_cnt;
    logic [NUM_CH-1:0][31:0]        csum;

    mm_read_bench #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ch_en(ch_en), .base_addr(base_addr),
        .total_beats(total_beats), .burst_len(burst_len),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast), .m_rdata(m_rdata),
        .busy(busy), .done(done), .cmd_cnt(cmd_cnt), .beat_cnt(beat_cnt),
        .cyc_cnt(cyc_cnt), .csum(csum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [7:0]  l;
    } ar_t;

    typedef struct {
        logic [1:0]  en;
        logic [63:0] b0;
        logic [31:0] t0;
        logic [63:0] b1;
        logic [31:0] t1;
        logic [7:0]  bl;
        logic [31:0] c0, n0, c1, n1;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    ar_t         exp_ar[NUM_CH][$];
    int          pend[NUM_CH][$];
    int          beat_idx[NUM_CH];
    logic [31:0] seen[NUM_CH];
    logic [31:0] tot_lat[NUM_CH];
    logic [31:0] exp_csum[NUM_CH];
    logic [31:0] cyc_exp[NUM_CH];
    int          ar_count[NUM_CH];
    bit          run[NUM_CH];
    bit          ar_rdy_en[NUM_CH];
    bit          rv_en[NUM_CH];
    bit          start_prev;
    bit          a5_mode;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endfunction

    // One clock cycle of the slave model: drive at negedge, observe handshakes,
    // then let the posedge happen and return 1ns after it.
    task automatic tick();
        @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
            m_arready[c] = ar_rdy_en[c];
            m_rvalid[c]  = 1'b0;
            m_rlast[c]   = 1'b0;
            if (rv_en[c] && pend[c].size() > 0) begin
                m_rvalid[c] = 1'b1;
                m_rlast[c]  = (beat_idx[c] == pend[c][0]);
            end
            for (int l = 0; l < LANES; l++) begin
                m_rdata[c][l*32 +: 32] = a5_mode ? 32'hA5A5_A5A5 : $urandom;
            end
        end
        #1;
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (run[c]) cyc_exp[c]++;
                if (m_arvalid[c] && m_arready[c]) begin
                    ar_count[c]++;
                    if (exp_ar[c].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL ar_unexpected ch%0d: got AR at 0x%0h, required none", c, m_araddr[c]);
                    end else begin
                        ar_t e;
                        e = exp_ar[c].pop_front();
                        check($sformatf("ar_addr ch%0d", c), m_araddr[c], e.a);
                        check($sformatf("ar_len ch%0d", c), 64'(m_arlen[c]), 64'(e.l));
                    end
                    pend[c].push_back(int'(m_arlen[c]));
                end
                if (m_rvalid[c] && m_rready[c]) begin
                    for (int l = 0; l < LANES; l++) exp_csum[c] ^= m_rdata[c][l*32 +: 32];
                    seen[c]++;
                    if (m_rlast[c]) begin
                        void'(pend[c].pop_front());
                        beat_idx[c] = 0;
                    end else begin
                        beat_idx[c]++;
                    end
                    if (run[c] && seen[c] == tot_lat[c]) run[c] = 1'b0;
                end
            end
            if (start && !start_prev) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ch_en[c] && !run[c]) begin
                        logic [63:0] a;
                        logic [31:0] r;
                        logic [7:0]  ln;
                        a = base_addr[c];
                        r = total_beats[c];
                        exp_ar[c].delete();
                        while (r != 0) begin
                            ln = ((r - 32'd1) < 32'(burst_len)) ? 8'(r - 32'd1) : burst_len;
                            exp_ar[c].push_back('{a, ln});
                            a = a + (64'(ln) + 64'd1) * 64'(DATA_W / 8);
                            r = r - (32'(ln) + 32'd1);
                        end
                        exp_csum[c] = 32'd0;
                        cyc_exp[c]  = 32'd0;
                        seen[c]     = 32'd0;
                        tot_lat[c]  = total_beats[c];
                        run[c]      = (total_beats[c] != 0);
                    end
                end
            end
            start_prev = start;
        end else begin
            start_prev = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                pend[c].delete();
                exp_ar[c].delete();
                run[c]      = 1'b0;
                beat_idx[c] = 0;
                seen[c]     = 32'd0;
                exp_csum[c] = 32'd0;
                cyc_exp[c]  = 32'd0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] en, input logic [63:0] b0, input logic [31:0] t0,
                          input logic [63:0] b1, input logic [31:0] t1, input logic [7:0] bl);
        ch_en          = en;
        base_addr[0]   = b0;
        total_beats[0] = t0;
        base_addr[1]   = b1;
        total_beats[1] = t1;
        burst_len      = bl;
        start          = 1'b1;
        tick();
        start          = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((run[0] || run[1]) && n < 3000) begin
            tick();
            n++;
        end
        if (run[0] || run[1]) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: run=%0b%0b after %0d cycles, required idle", tag, run[1], run[0], n);
        end
    endtask

    task automatic check_final(input string tag, input int c, input logic [31:0] cmd, input logic [31:0] beats);
        check($sformatf("%s done ch%0d", tag, c), 64'(done[c]), 64'd1);
        check($sformatf("%s busy ch%0d", tag, c), 64'(busy[c]), 64'd0);
        check($sformatf("%s cmd_cnt ch%0d", tag, c), 64'(cmd_cnt[c]), 64'(cmd));
        check($sformatf("%s beat_cnt ch%0d", tag, c), 64'(beat_cnt[c]), 64'(beats));
        check($sformatf("%s csum ch%0d", tag, c), 64'(csum[c]), 64'(exp_csum[c]));
        check($sformatf("%s cyc_cnt ch%0d", tag, c), 64'(cyc_cnt[c]), 64'(cyc_exp[c]));
        check($sformatf("%s ar_left ch%0d", tag, c), 64'(exp_ar[c].size()), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("%s flags ch%0d", tag, c),
                  64'({m_arvalid[c], m_rready[c], busy[c], done[c]}), 64'd0);
            check($sformatf("%s ar ch%0d", tag, c), m_araddr[c] | 64'(m_arlen[c]), 64'd0);
            check($sformatf("%s counters ch%0d", tag, c),
                  64'(cmd_cnt[c] | beat_cnt[c] | cyc_cnt[c] | csum[c]), 64'd0);
        end
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{2'b11, 64'h1000, 32'd32, 64'h8000, 32'd20, 8'd7,  32'd4, 32'd32, 32'd3,  32'd20};
        vecs[1] = '{2'b11, 64'h2040, 32'd1,  64'h0,    32'd17, 8'd15, 32'd1, 32'd1,  32'd2,  32'd17};
        vecs[2] = '{2'b11, 64'h0100, 32'd5,  64'h0300, 32'd3,  8'd0,  32'd5, 32'd5,  32'd3,  32'd3};
        vecs[3] = '{2'b11, 64'h4000, 32'd16, 64'h5000, 32'd33, 8'd15, 32'd1, 32'd16, 32'd3,  32'd33};
        vecs[4] = '{2'b01, 64'h6000, 32'd8,  64'h7000, 32'd99, 8'd3,  32'd2, 32'd8,  32'd3,  32'd33};
        vecs[5] = '{2'b11, 64'h9000, 32'd0,  64'hA000, 32'd9,  8'd3,  32'd0, 32'd0,  32'd3,  32'd9};

        rst = 1'b1; start = 1'b0; ch_en = '0; base_addr = '0; total_beats = '0; burst_len = '0;
        m_arready = '0; m_rvalid = '0; m_rlast = '0; m_rdata = '0;
        a5_mode = 1'b0; start_prev = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            ar_rdy_en[c] = 1'b1; rv_en[c] = 1'b1; run[c] = 1'b0; beat_idx[c] = 0;
            seen[c] = 0; tot_lat[c] = 0; exp_csum[c] = 0; cyc_exp[c] = 0; ar_count[c] = 0;
        end
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        check_zero("idle");

        for (int v = 0; v < 6; v++) begin
            launch(vecs[v].en, vecs[v].b0, vecs[v].t0, vecs[v].b1, vecs[v].t1, vecs[v].bl);
            wait_idle($sformatf("vec%0d", v));
            check_final($sformatf("vec%0d", v), 0, vecs[v].c0, vecs[v].n0);
            check_final($sformatf("vec%0d", v), 1, vecs[v].c1, vecs[v].n1);
        end

        // R stalled: outstanding limit caps issue; a second start edge is ignored
        rv_en[0] = 1'b0;
        ar_count[0] = 0;
        launch(2'b01, 64'h1000, 32'd32, 64'h0, 32'd0, 8'd7);
        repeat (5) tick();
        launch(2'b01, 64'hDEAD_0000, 32'd4, 64'h0, 32'd0, 8'd1);
        repeat (15) tick();
        check("stall ar_count", 64'(ar_count[0]), 64'd2);
        check("stall arvalid", 64'(m_arvalid[0]), 64'd0);
        check("stall busy", 64'(busy[0]), 64'd1);
        rv_en[0] = 1'b1;
        wait_idle("stall");
        check_final("stall", 0, 32'd4, 32'd32);

        // ch0 AR blocked, ch1 independent; then reset mid-issue and relaunch
        ar_rdy_en[0] = 1'b0;
        launch(2'b11, 64'h1000, 32'd32, 64'h3000, 32'd20, 8'd7);
        begin
            int n;
            n = 0;
            while (run[1] && n < 3000) begin
                tick();
                n++;
            end
            check("blocked ch1 finished", 64'(run[1]), 64'd0);
        end
        check_final("blocked", 1, 32'd3, 32'd20);
        check("blocked busy ch0", 64'(busy[0]), 64'd1);
        check("blocked cmd_cnt ch0", 64'(cmd_cnt[0]), 64'd0);
        check("blocked arvalid ch0", 64'(m_arvalid[0]), 64'd1);
        check("blocked araddr ch0", m_araddr[0], 64'h1000);
        check("blocked arlen ch0", 64'(m_arlen[0]), 64'd7);
        rst = 1'b1;
        tick();
        check_zero("midreset");
        rst = 1'b0;
        ar_rdy_en[0] = 1'b1;
        tick();
        check_zero("postreset");
        launch(2'b11, 64'h1000, 32'd32, 64'h3000, 32'd20, 8'd7);
        wait_idle("relaunch");
        check_final("relaunch", 0, 32'd4, 32'd32);
        check_final("relaunch", 1, 32'd3, 32'd20);

        // constant lanes cancel in pairs; zero-length run completes at once
        a5_mode = 1'b1;
        launch(2'b01, 64'h2000, 32'd1, 64'h0, 32'd0, 8'd7);
        wait_idle("a5");
        check("a5 csum", 64'(csum[0]), 64'd0);
        check("a5 cmd_cnt", 64'(cmd_cnt[0]), 64'd1);
        check("a5 beat_cnt", 64'(beat_cnt[0]), 64'd1);
        a5_mode = 1'b0;
        launch(2'b01, 64'h2000, 32'd0, 64'h0, 32'd0, 8'd7);
        check("zero done", 64'(done[0]), 64'd1);
        check("zero busy", 64'(busy[0]), 64'd0);
        check("zero cmd_cnt", 64'(cmd_cnt[0]), 64'd0);
        check("zero cyc_cnt", 64'(cyc_cnt[0]), 64'd0);
        check("zero arvalid", 64'(m_arvalid[0]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
